tof_cfg_regfile: RTL and testbench

//  Configuration register file feeding tof_controller: 65 DAC words + 1 power-enable word (66 x 16b).

---
 rtl/tof_cfg_pkg.sv | 29 ++
 rtl/tof_cfg_bank.sv | 66 ++++++
 rtl/tof_cfg_regfile.sv | 192 +++++++++++++++++++
 tb/tb_tof_cfg_regfile.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tof_cfg_pkg.sv
// rtl/tof_cfg_pkg.sv - shared constants and types for the ToF configuration register file
// Purpose: register count, host address map, FSM state encoding and STATUS bit positions.
// Ports: none (package).
package tof_cfg_pkg;

  localparam int          NREG   = 66;
  localparam int          AW     = 7;
  localparam int          DW     = 16;
  // Register count as an address-width constant so compares stay width-matched.
  localparam logic [AW-1:0] NREG_A = AW'(NREG);
  localparam logic [AW-1:0] LAST_A = AW'(NREG - 1);

  localparam logic [AW-1:0] ADDR_STATUS = 7'h7E;
  localparam logic [AW-1:0] ADDR_CTRL   = 7'h7F;

  // STATUS = {upd_cnt[7:0], 5'b0, ctrl_ready, dirty, busy}
  localparam int STAT_BUSY    = 0;
  localparam int STAT_DIRTY   = 1;
  localparam int STAT_READY   = 2;
  localparam int STAT_CNT_LSB = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COPY = 2'd1,
    REQ  = 2'd2,
    WAIT = 2'd3
  } state_t;

endpackage

// File: rtl/tof_cfg_bank.sv
// rtl/tof_cfg_bank.sv - NREG x 16 dual-bank storage: staging (host side) and active (controller side)
// Purpose: host writes/reads the staging bank, the copy port moves one staging word per cycle into
//          the active bank, and the controller reads the active bank through a registered port.
// Ports:
//   clk_i, rst_i          clock, asynchronous active-low reset (clears both banks)
//   host_wr_i/addr/dat    staging write port (out-of-range addresses ignored)
//   host_rd_dat_o         combinational staging word at host_addr_i (0 when out of range)
//   copy_en_i/copy_idx_i  copy staging[idx] -> active[idx]
//   cfg_addr_i/cfg_dat_o  registered active-bank read, 0 when out of range
module tof_cfg_bank
  import tof_cfg_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          host_wr_i,
  input  logic [AW-1:0] host_addr_i,
  input  logic [DW-1:0] host_dat_i,
  output logic [DW-1:0] host_rd_dat_o,
  input  logic          copy_en_i,
  input  logic [AW-1:0] copy_idx_i,
  input  logic [AW-1:0] cfg_addr_i,
  output logic [DW-1:0] cfg_dat_o
);

  logic [DW-1:0] r_stg [NREG];
  logic [DW-1:0] r_act [NREG];
  logic [DW-1:0] r_cfg_dat;

  logic w_host_in_range;
  logic w_copy_in_range;
  logic w_cfg_in_range;

  assign w_host_in_range = (host_addr_i < NREG_A);
  assign w_copy_in_range = (copy_idx_i < NREG_A);
  assign w_cfg_in_range  = (cfg_addr_i < NREG_A);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < NREG; i++) r_stg[i] <= '0;
    end else if (host_wr_i && w_host_in_range) begin
      r_stg[host_addr_i] <= host_dat_i;
    end
  end

  // The copy samples the pre-edge staging value, so a host write to the word being copied
  // in the same cycle stays in staging only and marks the bank dirty again.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < NREG; i++) r_act[i] <= '0;
    end else if (copy_en_i && w_copy_in_range) begin
      r_act[copy_idx_i] <= r_stg[copy_idx_i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cfg_dat <= '0;
    end else begin
      r_cfg_dat <= w_cfg_in_range ? r_act[cfg_addr_i] : '0;
    end
  end

  assign cfg_dat_o     = r_cfg_dat;
  assign host_rd_dat_o = w_host_in_range ? r_stg[host_addr_i] : '0;

endmodule

// File: rtl/tof_cfg_regfile.sv
// rtl/tof_cfg_regfile.sv - ToF config register file: host decode, commit FSM and update handshake
// Purpose: host writes staging words; GO (CTRL bit0) copies staging into the active bank one word
//          per cycle, then raises update_o to the controller until update_complete_i.
// Build option: TOF_CFG_AUTOCOMMIT_EN adds parameter HOLDOFF and an idle counter that issues an
//               internal GO HOLDOFF idle cycles after the last staging write.
// Ports:
//   clk_i, rst_i                 200 MHz clock, asynchronous active-low reset
//   host_addr_i/dat_i/wr_i/rd_i  host register access strobes (one cycle)
//   host_dat_o, host_ack_o       read data and ack, one cycle after the strobe
//   cfg_addr_i, cfg_dat_o        controller active-bank read, 1-cycle latency
//   ctrl_ready_i                 controller ready to accept an update
//   update_o, update_complete_i  update request level / done pulse
//   busy_o                       commit in progress (COPY/REQ/WAIT)
module tof_cfg_regfile
  import tof_cfg_pkg::*;
`ifdef TOF_CFG_AUTOCOMMIT_EN
#(
  parameter int unsigned HOLDOFF = 1024
)
`endif
(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [AW-1:0] host_addr_i,
  input  logic [DW-1:0] host_dat_i,
  input  logic          host_wr_i,
  input  logic          host_rd_i,
  output logic [DW-1:0] host_dat_o,
  output logic          host_ack_o,
  input  logic [AW-1:0] cfg_addr_i,
  output logic [DW-1:0] cfg_dat_o,
  input  logic          ctrl_ready_i,
  output logic          update_o,
  input  logic          update_complete_i,
  output logic          busy_o
);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_idx;
  logic          r_dirty;
  logic          r_pending;
  logic [7:0]    r_upd_cnt;
  logic          r_ack;
  logic [DW-1:0] r_rd_dat;

  logic          w_stg_sel;
  logic          w_stg_wr;
  logic          w_ctrl_go;
  logic          w_auto_go;
  logic          w_go;
  logic          w_busy;
  logic          w_copy_en;
  logic          w_start_copy;
  logic [DW-1:0] w_stg_rd_dat;
  logic [DW-1:0] w_status;
  logic [DW-1:0] w_rd_mux;

  assign w_stg_sel = (host_addr_i < NREG_A);
  assign w_stg_wr  = host_wr_i && w_stg_sel;
  assign w_ctrl_go = host_wr_i && (host_addr_i == ADDR_CTRL) && host_dat_i[0];
  assign w_go      = w_ctrl_go || w_auto_go;

`ifdef TOF_CFG_AUTOCOMMIT_EN
  localparam logic [15:0] HOLD_CNT = 16'(HOLDOFF);
  logic [15:0] r_idle_cnt;

  // Counts idle cycles only while there is something to commit; busy freezes it.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_idle_cnt <= '0;
    end else if (w_stg_wr) begin
      r_idle_cnt <= '0;
    end else if ((r_state == IDLE) && r_dirty && (r_idle_cnt != HOLD_CNT)) begin
      r_idle_cnt <= r_idle_cnt + 16'd1;
    end
  end

  assign w_auto_go = (r_state == IDLE) && r_dirty && (r_idle_cnt == HOLD_CNT);
`else
  assign w_auto_go = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_go || r_pending) w_state_nxt = COPY;
      COPY:    if (r_idx == LAST_A) w_state_nxt = REQ;
      REQ:     if (ctrl_ready_i) w_state_nxt = WAIT;
      WAIT:    if (update_complete_i) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM outputs: update_o is decoded from state so reset removes it without waiting for a clock.
  always_comb begin
    update_o  = 1'b0;
    w_busy    = 1'b1;
    w_copy_en = 1'b0;
    case (r_state)
      IDLE:    w_busy    = 1'b0;
      COPY:    w_copy_en = 1'b1;
      WAIT:    update_o  = 1'b1;
      default: ;
    endcase
  end

  assign busy_o       = w_busy;
  assign w_start_copy = (r_state == IDLE) && (w_state_nxt == COPY);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_idx <= '0;
    end else if (r_state == COPY) begin
      r_idx <= r_idx + 7'd1;
    end else begin
      r_idx <= '0;
    end
  end

  // A staging write wins over the first-cycle clear so a write during COPY is not lost.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_dirty <= 1'b0;
    end else if (w_stg_wr) begin
      r_dirty <= 1'b1;
    end else if ((r_state == COPY) && (r_idx == '0)) begin
      r_dirty <= 1'b0;
    end
  end

  // Any number of GOs while busy collapse into one follow-up commit.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_pending <= 1'b0;
    end else if (w_start_copy) begin
      r_pending <= 1'b0;
    end else if (w_busy && w_go) begin
      r_pending <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_upd_cnt <= '0;
    end else if ((r_state == WAIT) && update_complete_i) begin
      r_upd_cnt <= r_upd_cnt + 8'd1;
    end
  end

  assign w_status = {r_upd_cnt, 5'b0, ctrl_ready_i, r_dirty, w_busy};

  always_comb begin
    w_rd_mux = '0;
    if (w_stg_sel)                        w_rd_mux = w_stg_rd_dat;
    else if (host_addr_i == ADDR_STATUS)  w_rd_mux = w_status;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_ack    <= 1'b0;
      r_rd_dat <= '0;
    end else begin
      r_ack    <= host_wr_i || host_rd_i;
      r_rd_dat <= host_rd_i ? w_rd_mux : '0;
    end
  end

  assign host_ack_o = r_ack;
  assign host_dat_o = r_rd_dat;

  tof_cfg_bank u_bank (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .host_wr_i     (w_stg_wr),
    .host_addr_i   (host_addr_i),
    .host_dat_i    (host_dat_i),
    .host_rd_dat_o (w_stg_rd_dat),
    .copy_en_i     (w_copy_en),
    .copy_idx_i    (r_idx),
    .cfg_addr_i    (cfg_addr_i),
    .cfg_dat_o     (cfg_dat_o)
  );

endmodule

// File: tb/tb_tof_cfg_regfile.sv
// tb/tb_tof_cfg_regfile.sv - self-checking bench for tof_cfg_regfile
module tb_tof_cfg_regfile;

  localparam int N = 66;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [6:0]  host_addr_i = '0;
  logic [15:0] host_dat_i = '0;
  logic        host_wr_i = 1'b0;
  logic        host_rd_i = 1'b0;
  logic [15:0] host_dat_o;
  logic        host_ack_o;
  logic [6:0]  cfg_addr_i = '0;
  logic [15:0] cfg_dat_o;
  logic        ctrl_ready_i = 1'b0;
  logic        update_o;
  logic        update_complete_i = 1'b0;
  logic        busy_o;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  logic [15:0] m_stg [N];
  logic [15:0] m_act [N];
  int          m_cnt;
  bit          m_dirty;

  always #2.5 clk_i = ~clk_i;

  always @(posedge update_o) pulses++;

`ifdef TOF_CFG_AUTOCOMMIT_EN
  tof_cfg_regfile #(.HOLDOFF(16)) dut (
`else
  tof_cfg_regfile dut (
`endif
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .host_addr_i       (host_addr_i),
    .host_dat_i        (host_dat_i),
    .host_wr_i         (host_wr_i),
    .host_rd_i         (host_rd_i),
    .host_dat_o        (host_dat_o),
    .host_ack_o        (host_ack_o),
    .cfg_addr_i        (cfg_addr_i),
    .cfg_dat_o         (cfg_dat_o),
    .ctrl_ready_i      (ctrl_ready_i),
    .update_o          (update_o),
    .update_complete_i (update_complete_i),
    .busy_o            (busy_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_stg[i] = '0;
      m_act[i] = '0;
    end
    m_cnt   = 0;
    m_dirty = 1'b0;
  endtask

  function automatic logic [15:0] exp_read(input int a);
    if (a < N)          return m_stg[a];
    else if (a == 'h7E) return {8'(m_cnt), 5'b0, ctrl_ready_i, m_dirty, 1'b0};
    else                return 16'h0;
  endfunction

  task automatic host_write(input int a, input logic [15:0] d);
    host_addr_i = 7'(a);
    host_dat_i  = d;
    host_wr_i   = 1'b1;
    tick();
    host_wr_i   = 1'b0;
    chk("wr_ack", host_ack_o, 1);
    if (a < N) begin
      m_stg[a] = d;
      m_dirty  = 1'b1;
    end
  endtask

  task automatic host_read(input int a, input string tag);
    logic [15:0] e;
    e = exp_read(a);
    host_addr_i = 7'(a);
    host_rd_i   = 1'b1;
    tick();
    host_rd_i   = 1'b0;
    chk("rd_ack", host_ack_o, 1);
    chk(tag, host_dat_o, e);
  endtask

  task automatic cfg_check(input int a, input string tag);
    cfg_addr_i = 7'(a);
    tick();
    chk(tag, cfg_dat_o, (a < N) ? m_act[a] : 16'h0);
  endtask

  task automatic wait_upd(output int n);
    n = 0;
    while (update_o !== 1'b1 && n < 1000) begin
      tick();
      n++;
    end
    chk("upd_timeout", update_o, 1);
  endtask

  task automatic complete();
    update_complete_i = 1'b1;
    tick();
    update_complete_i = 1'b0;
    chk("upd_drop", update_o, 0);
    m_cnt = (m_cnt + 1) % 256;
  endtask

  // GO, wait for the request, then finish the handshake; the active bank takes the staging image.
  task automatic commit(input bit chk_lat);
    int n;
    host_write('h7F, 16'h0001);
    for (int i = 0; i < N; i++) m_act[i] = m_stg[i];
    m_dirty = 1'b0;
    wait_upd(n);
    if (chk_lat) chk("go_latency", n, 67);
    chk("busy_wait", busy_o, 1);
    complete();
  endtask

  initial begin
    int n;
    int p0;
    int a;
    logic [15:0] d;
    model_clear();

    // Reset state
    tick();
    chk("rst_update", update_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_ack", host_ack_o, 0);
    chk("rst_cfg", cfg_dat_o, 0);
    rst_i = 1'b1;
    tick();
    host_read('h7E, "rst_status");

    // 1: staging write/readback, active still zero
    host_write(5, 16'h1234);
    tick();
    chk("ack_one_cycle", host_ack_o, 0);
    host_read(5, "stg5");
    cfg_check(5, "cfg5_uncommitted");
    host_read('h7E, "status_dirty");

    // 2: commit with ready high
    ctrl_ready_i = 1'b1;
    commit(1'b1);
    cfg_check(5, "cfg5_committed");
    host_read('h7E, "status_after_commit");
    chk("status_0104", host_dat_o, 16'h0104);

    // 3: controller not ready holds the request
    ctrl_ready_i = 1'b0;
    host_write(3, 16'hA5A5);
    host_write('h7F, 16'h0001);
    for (int i = 0; i < N; i++) m_act[i] = m_stg[i];
    m_dirty = 1'b0;
    for (int i = 0; i < N + 50; i++) tick();
    chk("notready_upd", update_o, 0);
    chk("notready_busy", busy_o, 1);
    ctrl_ready_i = 1'b1;
    tick();
    chk("ready_upd", update_o, 1);
    complete();
    cfg_check(3, "cfg3");

    // 4: write during WAIT plus repeated GO -> exactly two update pulses
    p0 = pulses;
    host_write('h7F, 16'h0001);
    for (int i = 0; i < N; i++) m_act[i] = m_stg[i];
    m_dirty = 1'b0;
    wait_upd(n);
    host_write(7, 16'hBEEF);
    host_write('h7F, 16'h0001);
    host_write('h7F, 16'h0001);
    cfg_check(7, "cfg7_held");
    complete();
    for (int i = 0; i < N; i++) m_act[i] = m_stg[i];
    m_dirty = 1'b0;
    wait_upd(n);
    cfg_check(7, "cfg7_second");
    complete();
    for (int i = 0; i < 80; i++) tick();
    chk("two_pulses", pulses - p0, 2);
    host_read('h7E, "status_cnt");

    // 5: unmapped address and top word
    host_read('h50, "rd_unmapped");
    host_write('h50, 16'hFFFF);
    host_read('h50, "rd_unmapped2");
    host_write(65, 16'h00FF);
    commit(1'b0);
    cfg_check(65, "cfg65");
    cfg_check(66, "cfg66");
    cfg_check(127, "cfg127");

    // Random staging traffic, readbacks, then full active-bank compare
    for (int i = 0; i < 40; i++) begin
      a = $urandom_range(0, N - 1);
      d = 16'($urandom);
      host_write(a, d);
      if ((i % 4) == 0) host_read($urandom_range(0, 127), "rand_rd");
    end
    host_read('h7E, "status_rand");
    commit(1'b1);
    for (int i = 0; i < N; i++) cfg_check(i, "cfg_all");
    for (int i = 0; i < 8; i++) cfg_check($urandom_range(0, 127), "cfg_rand");

    // 6: async reset while the update is outstanding
`ifdef TOF_CFG_AUTOCOMMIT_EN
    host_write(0, 16'h0F0F);
    n = 0;
    while (busy_o !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("autocommit_delay", n, 17);
`else
    host_write(0, 16'h0F0F);
    host_write('h7F, 16'h0001);
`endif
    wait_upd(n);
    #1;
    rst_i = 1'b0;
    #1;
    chk("async_upd", update_o, 0);
    chk("async_busy", busy_o, 0);
    ctrl_ready_i = 1'b0;
    model_clear();
    tick();
    rst_i = 1'b1;
    tick();
    host_read('h7E, "status_after_rst");
    host_read(5, "stg_after_rst");
    cfg_check(5, "cfg_after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
